// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and constants for the cache miss-fill controller.
package cache_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned WORD_IDX_W  = 3;
  localparam int unsigned CNT_W       = WORD_IDX_W + 1;

  localparam logic [ADDR_W-1:0] BLOCK_OFFSET_MASK = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } fillState_e;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Saturating word counter for one side (issue or receive) of a block fill.
module fill_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  // Count enabled events, holding at BLOCK_WORDS once the block is complete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(BLOCK_WORDS));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss controller: fetches an 8-word block, writes the data array, then the tag.
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [ADDR_W-1:0]     miss_address,
  output logic                  fsm_busy,
  output logic                  mem_read_en,
  output logic [ADDR_W-1:0]     memory_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  write_data_array,
  output logic [WORD_IDX_W-1:0] data_word_idx,
  output logic [15:0]           data_wdata,
  output logic                  write_tag_array,
  output logic [ADDR_W-1:0]     fill_block_base
);

  fillState_e        state;
  fillState_e        nextState;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] nextBase;
  logic              cntClear;
  logic              issueEn;
  logic              recvEn;
  logic [CNT_W-1:0]  issueCnt;
  logic [CNT_W-1:0]  recvCnt;
  logic              issueDone;
  logic              recvDone;

  fill_counter u_issueCnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cntClear),
    .enable (issueEn),
    .count  (issueCnt),
    .done   (issueDone)
  );

  fill_counter u_recvCnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cntClear),
    .enable (recvEn),
    .count  (recvCnt),
    .done   (recvDone)
  );

  // State, latched block base and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      base     <= '0;
      fsm_busy <= 1'b0;
    end else begin
      state    <= nextState;
      base     <= nextBase;
      fsm_busy <= (nextState != IDLE);
    end
  end

  // Next state; issue and receive sides advance independently during FILL.
  always_comb begin
    nextState = state;
    nextBase  = base;
    cntClear  = 1'b0;
    issueEn   = 1'b0;
    recvEn    = 1'b0;
    case (state)
      IDLE: begin
        if (miss_detected) begin
          nextState = FILL;
          nextBase  = miss_address & BLOCK_OFFSET_MASK;
          cntClear  = 1'b1;
        end
      end
      FILL: begin
        issueEn = !issueDone;
        recvEn  = memory_data_valid && !recvDone;
        if (recvDone || (recvEn && (recvCnt == CNT_W'(BLOCK_WORDS - 1)))) begin
          nextState = TAG;
        end
      end
      TAG: begin
        nextState = IDLE;
        cntClear  = 1'b1;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Word addresses stay inside the block: the offset is OR'd into an aligned base.
  assign mem_read_en      = (state == FILL) && !issueDone;
  assign memory_address   = mem_read_en ? (base | ADDR_W'({issueCnt, 1'b0})) : '0;
  assign write_data_array = recvEn;
  assign data_word_idx    = recvCnt[WORD_IDX_W-1:0];
  assign data_wdata       = memory_data;
  assign write_tag_array  = (state == TAG);
  assign fill_block_base  = base;

endmodule
